invaders_input: RTL



---
 rtl/invaders_input.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/invaders_input.sv
// Purpose: conditions PS/2 key events and both joysticks into registered invaders_top buttons; coin is shaped into a fixed pulse.
// Latency: key toggle -> button 2 clk_sys edges; joystick -> button 2 edges; coin request rise -> btn_coin high 2 edges later.
// Backpressure: none; all outputs are levels, and coin edges arriving during a pulse or its gap are dropped, not queued.
//
// Ports:
//   clk_sys            system clock (clk_25p2 domain)
//   reset_n            synchronous active-low reset
//   ps2_key[10:0]      [10] event toggle, [9] pressed, [8:0] scan code ([8] = E0 extended)
//   joystick_0/1[15:0] [0] right, [1] left, [4] fire, [5] start 1P, [6] start 2P
//   btn_*              registered button levels to invaders_top; btn_coin is the shaped coin pulse
module invaders_input #(
    parameter int COIN_CYCLES = 2520000,
    parameter int GAP_CYCLES  = 2520000,
    parameter int LR_NEUTRAL  = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    output logic        btn_fire,
    output logic        btn_left,
    output logic        btn_right,
    output logic        btn_one_player,
    output logic        btn_two_player,
    output logic        btn_coin
);

    localparam int MAX_CYCLES = (COIN_CYCLES > GAP_CYCLES) ? COIN_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } coin_state_t;

    // ---------------------------------------------------------------
    // PS/2 event detect and held key latches
    // ---------------------------------------------------------------
    logic tog_q;
    logic key_evt;
    logic key_space, key_lctrl, key_f1, key_f2;
    logic key_a, key_eleft, key_d, key_eright, key_c;

    assign key_evt = ps2_key[10] != tog_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            // Track the toggle through reset so a level change during reset
            // is not mistaken for a key event afterwards.
            tog_q      <= ps2_key[10];
            key_space  <= 1'b0;
            key_lctrl  <= 1'b0;
            key_f1     <= 1'b0;
            key_f2     <= 1'b0;
            key_a      <= 1'b0;
            key_eleft  <= 1'b0;
            key_d      <= 1'b0;
            key_eright <= 1'b0;
            key_c      <= 1'b0;
        end else begin
            tog_q <= ps2_key[10];
            if (key_evt) begin
                // Full 9-bit compare: keypad 4 (0x06B) must not alias E0-Left.
                case (ps2_key[8:0])
                    9'h029:  key_space  <= ps2_key[9];
                    9'h014:  key_lctrl  <= ps2_key[9];
                    9'h005:  key_f1     <= ps2_key[9];
                    9'h006:  key_f2     <= ps2_key[9];
                    9'h01C:  key_a      <= ps2_key[9];
                    9'h16B:  key_eleft  <= ps2_key[9];
                    9'h023:  key_d      <= ps2_key[9];
                    9'h174:  key_eright <= ps2_key[9];
                    9'h021:  key_c      <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Joystick register. Deliberately not reset: it keeps sampling the
    // live sticks during reset so a start button held through reset is
    // seen as an already-high coin level, not as a fresh edge.
    // ---------------------------------------------------------------
    logic [6:0] joy_q;

    always_ff @(posedge clk_sys) begin
        joy_q <= joystick_0[6:0] | joystick_1[6:0];
    end

    logic unused_joy_bits;
    assign unused_joy_bits = ^{joystick_0[15:7], joystick_1[15:7], joy_q[3:2]};

    // ---------------------------------------------------------------
    // Request merge and left/right resolve
    // ---------------------------------------------------------------
    logic fire_req, start1_req, start2_req, left_req, right_req, coin_req;
    logic lr_cancel;

    assign fire_req   = key_space | key_lctrl | joy_q[4];
    assign start1_req = key_f1 | joy_q[5];
    assign start2_req = key_f2 | joy_q[6];
    assign left_req   = key_a | key_eleft | joy_q[1];
    assign right_req  = key_d | key_eright | joy_q[0];
    assign coin_req   = key_c | joy_q[5] | joy_q[6];
    assign lr_cancel  = (LR_NEUTRAL != 0) && left_req && right_req;

    // ---------------------------------------------------------------
    // Coin edge detect and pulse shaper
    // ---------------------------------------------------------------
    logic        coin_q;
    logic        coin_rise;
    coin_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    assign coin_rise = coin_req & ~coin_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            // Preset high so a coin request held through reset gives no edge.
            coin_q <= 1'b1;
            state  <= ST_IDLE;
            cnt    <= '0;
        end else begin
            coin_q <= coin_req;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (coin_rise) begin
                    cnt_nxt   = COIN_LOAD;
                    state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    cnt_nxt   = GAP_LOAD;
                    state_nxt = ST_GAP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                // Edges seen here are dropped; coin_q still tracks the level,
                // so a request held across the gap needs a fresh edge.
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            btn_fire       <= 1'b0;
            btn_left       <= 1'b0;
            btn_right      <= 1'b0;
            btn_one_player <= 1'b0;
            btn_two_player <= 1'b0;
            btn_coin       <= 1'b0;
        end else begin
            btn_fire       <= fire_req;
            btn_left       <= left_req & ~lr_cancel;
            btn_right      <= right_req & ~lr_cancel;
            btn_one_player <= start1_req;
            btn_two_player <= start2_req;
            btn_coin       <= (state == ST_PULSE);
        end
    end

endmodule
